sequenciador_servos: RTL and testbench

Command sequencer for the gripper/rotation servos of the cube robot. Accepts move commands (servo index + target position) over a valid/ready handshake, queues them, and applies them one at a time to the per-servo `largura` select lines that feed the `circuito_pwm` instances. After each move it holds for a fixed settle time before the next command. It signals completion of each move so the solver FSM can track progress.

---
 rtl/sequenciador_servos.sv | 165 ++++++++++++++++
 tb/tb_sequenciador_servos.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_servos.sv
// Servo move sequencer: queues (servo, position) commands and applies them one at a time
// with a settle wait. Define SEQ_CMD_FIFO_EN for a PROFUNDIDADE-entry FIFO (single entry otherwise).
module sequenciador_servos #(
    parameter int unsigned N_SERVOS     = 4,
    parameter int unsigned TEMPO_ESPERA = 50_000_000,
    parameter int unsigned PROFUNDIDADE = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd_servo,
    input  logic                cmd_pos,
    output logic                cmd_ready,
    output logic [N_SERVOS-1:0] largura,
    output logic                done,
    output logic                erro,
    output logic                ocupado
);

    if (N_SERVOS < 1 || N_SERVOS > 4) begin : g_bad_servos
        $error("N_SERVOS must be 1..4");
    end
    if (TEMPO_ESPERA < 1) begin : g_bad_tempo
        $error("TEMPO_ESPERA must be at least 1");
    end
    if (PROFUNDIDADE < 2 || (PROFUNDIDADE & (PROFUNDIDADE - 1)) != 0) begin : g_bad_prof
        $error("PROFUNDIDADE must be a power of 2, at least 2");
    end

    typedef enum logic [1:0] {OCIOSO, APLICA, ESPERA, CONCLUI} estado_t;

    estado_t     estado;
    estado_t     proximo;
    logic        push;
    logic        pop;
    logic        vazio;
    logic [1:0]  head_servo;
    logic        head_pos;
    logic [1:0]  servo_r;
    logic        pos_r;
    logic        erro_r;
    logic        servo_ok;
    logic [31:0] contador;

    assign push = cmd_valid && cmd_ready;
    assign pop  = (estado == OCIOSO) && !vazio;

`ifdef SEQ_CMD_FIFO_EN
    localparam int unsigned AW = $clog2(PROFUNDIDADE);
    localparam logic [AW:0] CHEIO = (AW + 1)'(PROFUNDIDADE);

    logic [1:0]    mem_servo [PROFUNDIDADE];
    logic          mem_pos   [PROFUNDIDADE];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   ocupacao;

    assign cmd_ready  = ocupacao < CHEIO;
    assign vazio      = ocupacao == '0;
    assign head_servo = mem_servo[rd_ptr];
    assign head_pos   = mem_pos[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            ocupacao <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   ocupacao <= ocupacao + 1'b1;
                2'b01:   ocupacao <= ocupacao - 1'b1;
                default: ocupacao <= ocupacao;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_servo[wr_ptr] <= cmd_servo;
            mem_pos[wr_ptr]   <= cmd_pos;
        end
    end
`else
    logic       cheio;
    logic [1:0] buf_servo;
    logic       buf_pos;

    assign cmd_ready  = !cheio;
    assign vazio      = !cheio;
    assign head_servo = buf_servo;
    assign head_pos   = buf_pos;

    // push requires empty and pop requires full, so they never coincide
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cheio     <= 1'b0;
            buf_servo <= '0;
            buf_pos   <= 1'b0;
        end else if (push) begin
            cheio     <= 1'b1;
            buf_servo <= cmd_servo;
            buf_pos   <= cmd_pos;
        end else if (pop) begin
            cheio     <= 1'b0;
        end
    end
`endif

    assign servo_ok = 32'(servo_r) < N_SERVOS;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= OCIOSO;
        else       estado <= proximo;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            servo_r  <= '0;
            pos_r    <= 1'b0;
            erro_r   <= 1'b0;
            contador <= '0;
            largura  <= '0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (!vazio) begin
                        servo_r <= head_servo;
                        pos_r   <= head_pos;
                    end
                end
                APLICA: begin
                    contador <= '0;
                    erro_r   <= !servo_ok;
                    for (int unsigned i = 0; i < N_SERVOS; i++) begin
                        if (servo_r == i[1:0]) largura[i] <= pos_r;
                    end
                end
                ESPERA:  contador <= contador + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        proximo = estado;
        done    = 1'b0;
        erro    = 1'b0;
        ocupado = (estado != OCIOSO) || !vazio;
        case (estado)
            OCIOSO:  if (!vazio) proximo = APLICA;
            APLICA:  proximo = ESPERA;
            // an out-of-range move passes through ESPERA for a single cycle, so done/erro follow E3
            ESPERA:  if (erro_r || contador == 32'(TEMPO_ESPERA - 1)) proximo = CONCLUI;
            CONCLUI: begin
                proximo = OCIOSO;
                done    = 1'b1;
                erro    = erro_r;
            end
            default: proximo = OCIOSO;
        endcase
    end

endmodule

// File: tb/tb_sequenciador_servos.sv
// Scoreboard bench for sequenciador_servos: each accepted command pushes its expected
// done edge and largura; each done pulse pops and compares.
module tb_sequenciador_servos;

    localparam int unsigned T  = 10;
    localparam int unsigned NS = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_servo = '0;
    logic       cmd_pos = 1'b0;
    logic       cmd_ready;
    logic [3:0] largura;
    logic       done;
    logic       erro;
    logic       ocupado;

    logic       cmd_valid3 = 1'b0;
    logic [1:0] cmd_servo3 = '0;
    logic       cmd_pos3 = 1'b0;
    logic       cmd_ready3;
    logic [2:0] largura3;
    logic       done3;
    logic       erro3;
    logic       ocupado3;

    always #5 clock = ~clock;

    sequenciador_servos #(.N_SERVOS(NS), .TEMPO_ESPERA(T), .PROFUNDIDADE(4)) dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_servo(cmd_servo),
        .cmd_pos(cmd_pos), .cmd_ready(cmd_ready), .largura(largura), .done(done),
        .erro(erro), .ocupado(ocupado)
    );

    sequenciador_servos #(.N_SERVOS(3), .TEMPO_ESPERA(T), .PROFUNDIDADE(4)) dut3 (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid3), .cmd_servo(cmd_servo3),
        .cmd_pos(cmd_pos3), .cmd_ready(cmd_ready3), .largura(largura3), .done(done3),
        .erro(erro3), .ocupado(ocupado3)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    typedef struct {
        int         done_edge;
        logic [3:0] larg;
        logic       erro;
    } exp_t;

    exp_t       sb[$];
    exp_t       new_e;
    exp_t       got_e;
    int         edge_n = 0;
    int         last_done = -100;
    int         pop_e;
    logic [3:0] model_larg = '0;

    // reference model: pops no earlier than one edge after accept or two after the previous done
    always @(posedge clock) begin
        edge_n = edge_n + 1;
        if (!reset && cmd_valid && cmd_ready) begin
            pop_e = (edge_n + 1 > last_done + 2) ? edge_n + 1 : last_done + 2;
            if (32'(cmd_servo) < NS) begin
                model_larg[cmd_servo] = cmd_pos;
                new_e.done_edge = pop_e + 1 + int'(T);
                new_e.erro      = 1'b0;
            end else begin
                new_e.done_edge = pop_e + 2;
                new_e.erro      = 1'b1;
            end
            new_e.larg = model_larg;
            last_done  = new_e.done_edge;
            sb.push_back(new_e);
        end
    end

    always @(negedge clock) begin
        if (!reset && (done || erro)) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                got_e = sb.pop_front();
                check("done_edge", edge_n, got_e.done_edge);
                check("done_largura", largura, got_e.larg);
                check("done_erro", erro, got_e.erro);
                check("erro_has_done", done, 1'b1);
            end
        end
    end

    task automatic flush_model();
        sb.delete();
        model_larg = '0;
        last_done  = -100;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush_model();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // called at a negedge; returns at the negedge after the accepting edge with valid dropped
    task automatic send(input logic [1:0] s, input logic p, output int acc);
        int w;
        cmd_valid = 1'b1;
        cmd_servo = s;
        cmd_pos   = p;
        w = 0;
        while (!cmd_ready && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (w >= 200) check("ready_timeout", cmd_ready, 1'b1);
        acc = edge_n + 1;
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_edge(input int t);
        while (edge_n < t) @(negedge clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clock);
        check("drain", sb.size(), 0);
        repeat (3) @(negedge clock);
    endtask

    int a, b, c;

    initial begin
        repeat (2) @(negedge clock);
        check("rst_largura", largura, 4'b0000);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_ocupado", ocupado, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_erro", erro, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // single move, servo 2 -> 1
        send(2'd2, 1'b1, a);
        check("ocupado_rise", ocupado, 1'b1);
        @(negedge clock);
        check("largura_e1", largura, 4'b0000);
        @(negedge clock);
        check("largura_e2", largura, 4'b0100);
        wait_edge(a + 12);
        check("ocupado_concl", ocupado, 1'b1);
        wait_edge(a + 13);
        check("ocupado_fall", ocupado, 1'b0);
        drain();

        // out-of-range on the three-servo instance
        cmd_valid3 = 1'b1; cmd_servo3 = 2'd3; cmd_pos3 = 1'b1;
        @(negedge clock);
        cmd_valid3 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            check("oor_done", done3, k == 3);
            check("oor_erro", erro3, k == 3);
        end
        check("oor_largura", largura3, 3'b000);
        cmd_valid3 = 1'b1; cmd_servo3 = 2'd1; cmd_pos3 = 1'b1;
        @(negedge clock);
        cmd_valid3 = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            check("ok3_done", done3, k == 12);
            if (k == 12) check("ok3_erro", erro3, 1'b0);
        end
        check("ok3_largura", largura3, 3'b010);

        // six queued moves with cmd_valid held
        do_reset();
        send(2'd0, 1'b1, a);
`ifdef SEQ_CMD_FIFO_EN
        check("ready_after_1", cmd_ready, 1'b1);
`else
        check("ready_after_1", cmd_ready, 1'b0);
`endif
        send(2'd1, 1'b1, b);
`ifndef SEQ_CMD_FIFO_EN
        check("accept_after_pop", b, a + 2);
`endif
        send(2'd2, 1'b1, c);
        send(2'd3, 1'b1, c);
        send(2'd0, 1'b0, c);
`ifdef SEQ_CMD_FIFO_EN
        check("ready_full", cmd_ready, 1'b0);
        check("fifo_accept_5", c, a + 4);
`endif
        send(2'd1, 1'b0, c);
        drain();
        check("seq_final", largura, 4'b1100);

        // reset mid-ESPERA with commands queued
        do_reset();
        send(2'd1, 1'b1, a);
        send(2'd2, 1'b1, b);
`ifdef SEQ_CMD_FIFO_EN
        send(2'd3, 1'b1, c);
`endif
        wait_edge(a + 7);
        check("pre_rst_largura", largura, 4'b0010);
        #2;
        reset = 1'b1;
        flush_model();
        #1;
        check("async_largura", largura, 4'b0000);
        check("async_ready", cmd_ready, 1'b1);
        check("async_ocupado", ocupado, 1'b0);
        check("async_done", done, 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        check("idle_after_rst", ocupado, 1'b0);
        send(2'd3, 1'b1, a);
        drain();
        check("post_rst_largura", largura, 4'b1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
